fetch_prefetch_unit: RTL
========================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of queue entries (power of 2, 2..16).
REQ-002 SHALL provide parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port Consume, input, 1, decode stage accepts queue head this cycle (PCWrite AND IF_IDWrite from hazard logic).
REQ-006 SHALL have port Flush, input, 1, redirect request (IF_Flush from hazard logic).
REQ-007 SHALL have port FlushTarget, input, 32, redirect address, sampled when Flush=1.
REQ-008 SHALL have ports ImemReq output 1, ImemAddr output 32, ImemAck input 1, and ImemData input 32, forming the instruction-memory handshake.
REQ-009 SHALL have ports Instr output 32, InstrPC4 output 32 (fetch address + 4), and InstrValid output 1, feeding the IF/ID register.

Function
REQ-010 SHALL hold a DEPTH-entry FIFO of {instruction, PC+4}; Instr/InstrPC4 show the head combinationally; InstrValid=1 iff count>0; Instr=32'h0 and InstrPC4=32'h0 when empty.
REQ-011 SHALL implement FSM IDLE/WAIT/DRAIN; reset state IDLE.
REQ-012 IDLE: if count<DEPTH and Flush=0, drive ImemReq=1 with ImemAddr=FetchPC; ack same cycle completes; else go to WAIT.
REQ-013 WAIT: hold ImemReq=1 and ImemAddr stable until ImemAck=1, then return to IDLE.
REQ-014 SHALL allow at most one outstanding request; ack with ImemReq=0 is ignored.
REQ-015 On accepted ack (not discarded): push {ImemData, FetchPC+4}, FetchPC+=4 (mod 2^32 wrap); entry visible next cycle.
REQ-016 Consume=1 with count>0 SHALL pop head; Consume with empty queue SHALL be ignored.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged, including when full.
REQ-018 Flush SHALL clear the queue and load FetchPC=FlushTarget next cycle; Flush beats simultaneous Consume and ack.
REQ-019 Flush while a request is pending and not acked same cycle SHALL enter DRAIN: ImemReq stays 1, address unchanged; response discarded on ack; then IDLE.
REQ-020 ImemReq SHALL not issue a new request in the Flush cycle; the first post-flush request is issued the next cycle from FlushTarget.
REQ-021 Flush during DRAIN SHALL update FetchPC to the newest FlushTarget and remain in DRAIN.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE, count=0, FetchPC=RESET_PC, ImemReq=0, InstrValid=0, Instr=0, InstrPC4=0.
REQ-023 Reset mid-request SHALL abandon the handshake; any ack during reset is ignored.
REQ-024 First request SHALL occur in the first clk edge-cycle after reset deasserts.

Configuration
REQ-025 With macro FETCH_PERF_CNT_EN defined, SHALL add output StallCount (16) counting cycles with InstrValid=0 while reset=1, saturating at 16'hFFFF, cleared by reset or Flush.
REQ-026 Without FETCH_PERF_CNT_EN, StallCount port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset release, ImemAck tied 1, ImemData=addr: cycle 0 ImemAddr=0; cycle 1 InstrValid=1, Instr=0, InstrPC4=4.
REQ-028 Consume=0, ack always 1, DEPTH=4: exactly 4 requests, then ImemReq=0; count stays 4; Consume pulse pops and frees one request.
REQ-029 Ack delayed 3 cycles: ImemAddr stable across WAIT; one push only.
REQ-030 Flush with FlushTarget=32'h100 while WAIT pending: stale data never appears; next Instr from address 32'h100, InstrPC4=32'h104.
REQ-031 Flush, Consume, and ack all in the same cycle with queue full: queue empty next cycle; next fetch at FlushTarget.
REQ-032 FetchPC=32'hFFFFFFFC fetched: InstrPC4=0; next ImemAddr=0; with FETCH_PERF_CNT_EN, StallCount increments only on empty cycles.

Source files
------------

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch/prefetch unit bus: hazard-control inputs, instruction-memory handshake, IF/ID feed.
// FETCH_PERF_CNT_EN adds the StallCount performance counter signal.
interface fetch_prefetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            Consume;
  logic            Flush;
  logic [XLEN-1:0] FlushTarget;
  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemAck;
  logic [XLEN-1:0] ImemData;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] InstrPC4;
  logic            InstrValid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]     StallCount;
`endif

  // Fetch unit side
  modport master (
    input  Consume, Flush, FlushTarget, ImemAck, ImemData,
    output ImemReq, ImemAddr, Instr, InstrPC4, InstrValid
`ifdef FETCH_PERF_CNT_EN
    , output StallCount
`endif
  );

  // Environment side: hazard logic, instruction memory and IF/ID register
  modport slave (
    output Consume, Flush, FlushTarget, ImemAck, ImemData,
    input  ImemReq, ImemAddr, Instr, InstrPC4, InstrValid
`ifdef FETCH_PERF_CNT_EN
    , input StallCount
`endif
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch queue with a single-outstanding instruction-memory handshake and flush redirect.
// Optional stall-cycle counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   reset,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [XLEN-1:0]   req_addr_q;
  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic              req_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic              not_full_c;
  logic              not_empty_c;
  logic [XLEN-1:0]   addr_c;
  entry_t            head_c;

  assign not_full_c  = (count_q < CNT_W'(DEPTH));
  assign not_empty_c = (count_q != '0);
  assign head_c      = mem_q[rd_ptr_q];

  // Next state and handshake decode; a pending request keeps its own address across a flush
  always_comb begin
    state_d  = state_q;
    req_c    = 1'b0;
    accept_c = 1'b0;
    addr_c   = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.Flush && not_full_c) begin
          req_c = 1'b1;
          if (bus.ImemAck) begin
            accept_c = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c  = 1'b1;
        addr_c = req_addr_q;
        if (bus.ImemAck) begin
          accept_c = !bus.Flush;
          state_d  = S_IDLE;
        end else if (bus.Flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        req_c  = 1'b1;
        addr_c = req_addr_q;
        if (bus.ImemAck) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      req_c    = 1'b0;
      accept_c = 1'b0;
    end
  end

  assign push_c = accept_c;
  assign pop_c  = bus.Consume && not_empty_c && !bus.Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch address and the address held by an in-flight request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      if (state_q == S_IDLE) begin
        req_addr_q <= fetch_pc_q;
      end
      if (bus.Flush) begin
        fetch_pc_q <= bus.FlushTarget;
      end else if (accept_c) begin
        fetch_pc_q <= fetch_pc_q + XLEN'(4);
      end
    end
  end

  // Queue pointers and occupancy; flush empties the queue regardless of push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.Flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= '{instr: bus.ImemData, pc4: addr_c + XLEN'(4)};
    end
  end

  assign bus.ImemReq    = req_c;
  assign bus.ImemAddr   = addr_c;
  assign bus.InstrValid = not_empty_c;
  assign bus.Instr      = not_empty_c ? head_c.instr : '0;
  assign bus.InstrPC4   = not_empty_c ? head_c.pc4   : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles with nothing to hand to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (bus.Flush) begin
      stall_cnt_q <= '0;
    end else if (!not_empty_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.StallCount = stall_cnt_q;
`endif

endmodule
